// File: rtl/tage_port_sched_pkg.sv
// Shared types for the TAGE predictor port scheduler: branch domains,
// the queued training-update record and the per-cycle port grant.
package tage_port_sched_pkg;

    typedef enum logic [1:0] {
        DOM_USER    = 2'd0,
        DOM_SUPER   = 2'd1,
        DOM_HYP     = 2'd2,
        DOM_MACHINE = 2'd3
    } domain_t;

    typedef struct packed {
        logic [31:0] idx;
        domain_t     domain;
        logic [31:0] targ;
        logic        br_result;
        logic        correct;
    } tage_upd_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_LKP  = 2'd1,
        GNT_UPD  = 2'd2
    } grant_e;

endpackage

// File: rtl/tage_upd_fifo.sv
// In-order queue of pending predictor training updates.
// Flush empties it at the clock edge; pushes are ignored while full or flushing.
module tage_upd_fifo
    import tage_port_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           push_i,
    input  tage_upd_t                      push_data_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    output tage_upd_t                      head_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o,
    output logic                           full_o,
    output logic                           empty_o
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    tage_upd_t     mem_q [DEPTH];
    tage_upd_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push_i && !full_o && !flush_i;
        do_pop   = pop_i && !empty_o;

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tage_port_sched.sv
// Arbitrates the predictor's single index/update port between fetch lookups
// and queued commit updates, with a starvation guard that forces update slots.
module tage_port_sched
    import tage_port_sched_pkg::*;
#(
    parameter int UPD_DEPTH  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              lkp_valid_i,
    input  logic [31:0]                       lkp_idx_i,
    input  domain_t                           lkp_domain_i,
    output logic                              lkp_ready_o,
    output logic                              lkp_pred_valid_o,
    output logic                              lkp_pred_o,
    output logic [31:0]                       lkp_targ_o,
    input  logic                              upd_valid_i,
    output logic                              upd_ready_o,
    input  logic [31:0]                       upd_idx_i,
    input  domain_t                           upd_domain_i,
    input  logic [31:0]                       upd_targ_i,
    input  logic                              upd_br_result_i,
    input  logic                              upd_correct_i,
    input  logic                              flush_i,
    output logic [$clog2(UPD_DEPTH+1)-1:0]    upd_count_o,
    output logic [31:0]                       tp_idx_o,
    output domain_t                           tp_domain_o,
    output logic [31:0]                       tp_targ_o,
    output logic                              tp_br_result_o,
    output logic                              tp_correct_o,
    output logic                              tp_update_en_o,
    input  logic                              tp_prediction_i,
    input  logic [31:0]                       tp_targ_i
);

    localparam int SW = $clog2(STARVE_MAX+1);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

    grant_e        grant;
    tage_upd_t     push_data;
    tage_upd_t     head;
    logic          fifo_full, fifo_empty;
    logic          push, pop, force_upd;
    logic [SW-1:0] starve_q, starve_d;
    logic          pred_valid_q, pred_valid_d;

    tage_upd_fifo #(
        .DEPTH (UPD_DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (flush_i),
        .head_o      (head),
        .count_o     (upd_count_o),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    always_comb begin
        push_data.idx       = upd_idx_i;
        push_data.domain    = upd_domain_i;
        push_data.targ      = upd_targ_i;
        push_data.br_result = upd_br_result_i;
        push_data.correct   = upd_correct_i;
    end

    // Lookups win by default; a saturated starve counter steals the slot.
    always_comb begin
        force_upd   = (starve_q == STARVE_MAX_C) && !fifo_empty;
        lkp_ready_o = !force_upd;
        upd_ready_o = !fifo_full && !flush_i;
        push        = upd_valid_i && upd_ready_o;
        if (lkp_valid_i && !force_upd) begin
            grant = GNT_LKP;
        end else if (!fifo_empty) begin
            grant = GNT_UPD;
        end else begin
            grant = GNT_NONE;
        end
        pop = (grant == GNT_UPD);
    end

    always_comb begin
        tp_idx_o       = '0;
        tp_domain_o    = DOM_USER;
        tp_targ_o      = '0;
        tp_br_result_o = 1'b0;
        tp_correct_o   = 1'b0;
        tp_update_en_o = 1'b0;
        case (grant)
            GNT_LKP: begin
                tp_idx_o    = lkp_idx_i;
                tp_domain_o = lkp_domain_i;
            end
            GNT_UPD: begin
                tp_idx_o       = head.idx;
                tp_domain_o    = head.domain;
                tp_targ_o      = head.targ;
                tp_br_result_o = head.br_result;
                tp_correct_o   = head.correct;
                tp_update_en_o = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        starve_d     = starve_q;
        pred_valid_d = (grant == GNT_LKP);
        if (flush_i || fifo_empty || grant == GNT_UPD) begin
            starve_d = '0;
        end else if (starve_q != STARVE_MAX_C) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            starve_q     <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            starve_q     <= starve_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    assign lkp_pred_valid_o = pred_valid_q;
    assign lkp_pred_o       = pred_valid_q & tp_prediction_i;
    assign lkp_targ_o       = pred_valid_q ? tp_targ_i : '0;

endmodule
